pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//   Registered, STAGES-deep carry-pipelined adder/subtractor with valid/ready handshake.
//   Splits the WIDTH-bit operation into STAGES equal chunks. Each stage resolves one chunk
//   and registers the carry into the next stage. This breaks the long full-adder carry
//   chain, so wide datapath arithmetic closes timing at the core clock.
// PARAMETERS
//   WIDTH   16  operand/result width in bits; must be a multiple of STAGES
//   STAGES   4  pipeline depth = latency in cycles; 1..WIDTH; CHUNK = WIDTH/STAGES bits per stage
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands valid this cycle
//   in_ready   out  1      block accepts operands this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add) / borrow-in (sub)
//   sub        in   1      0: a+b+cin; 1: a-b-cin
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result
//   co         out  1      final carry-out (sub: 1 = no borrow)
//   ovf        out  1      two's-complement signed overflow
// BEHAVIOUR
//   - Reset: all stage valid bits=0, out_valid=0, sum=0, co=0, ovf=0; in-flight ops discarded.
//   - Arithmetic: b_eff = sub ? ~b : b; c0 = cin ^ sub; {co,sum} = a + b_eff + c0 (WIDTH+1 bits).
//   - ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
//   - Stage k (0..STAGES-1) adds chunk k of a/b_eff with carry from stage k-1 (stage 0: c0).
//   - Operand chunks above k are skew-delayed; result chunks below k are de-skewed, so all
//     result bits of one op appear together.
//   - Handshake: transfer when valid&&ready on either side.
//   - Pipeline advances as a unit: adv = !out_valid || out_ready; in_ready = adv (combinational).
//   - Latency: an op accepted at edge N is presented at edge N+STAGES when not stalled.
//     Throughput: 1 op/cycle.
//   - Stall: out_valid&&!out_ready freezes every stage register; sum/co/ovf held stable.
//     No op lost or duplicated; issue order preserved.
//   - Bubbles: in_valid=0 while adv=1 inserts a bubble; the stage valid bit clears.
//     The bubble's data registers may hold stale values.
//   - Simultaneous output pop and input push in the same cycle: both occur, no stall bubble.
//   - rst asserted mid-stream wins over all handshakes in that cycle.
//   - STAGES=1: single registered full-width add, latency 1.
//   - Elaboration error if WIDTH % STAGES != 0.
//   - Chunk adders are built from the team's fa cell (ripple within a chunk).
// CONFIGURATION
//   SATURATE_EN defined:
//     - when ovf=1, sum is clamped to 0x7F..F if the true result is positive,
//       0x80..0 if negative (sign of a selects).
//     - ovf and co still report the raw condition.
//     - adds one mux on the final stage; latency unchanged.
//   SATURATE_EN undefined: sum is the raw modulo-2^WIDTH result.
// TESTING (WIDTH=16, STAGES=4 unless noted)
//   1. add a=FFFF b=0001 cin=0 -> 4 cycles later sum=0000 co=1 ovf=0.
//   2. add a=7FFF b=0001 -> ovf=1; sum=8000 (no macro); sum=7FFF (SATURATE_EN).
//   3. sub a=0005 b=0007 cin=0 -> sum=FFFE co=0 ovf=0.
//      sub a=8000 b=0001 -> ovf=1; sum=7FFF raw; sum=8000 with SATURATE_EN.
//   4. 8 back-to-back random ops, out_ready=0 on cycles 5-7:
//      - in_ready=0 exactly while stalled; sum held.
//      - results match reference model, in order, none lost.
//   5. rst pulsed 1 cycle with 3 ops in flight -> out_valid=0 next cycle, no stale result later.
//   6. STAGES=1 and STAGES=16: 1000 random add/sub ops -> match model; latency = STAGES.

Source files
------------

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep carry-pipelined adder/subtractor with valid/ready handshake
//
// Purpose: computes {co,sum} = a + (sub ? ~b : b) + (cin ^ sub) over WIDTH bits.
//   The carry chain is split into STAGES chunks of CHUNK = WIDTH/STAGES bits. Each stage
//   ripples one chunk and registers its carry. Pending operand chunks travel skewed
//   alongside, and resolved result chunks are carried forward so one op's bits leave together.
//   The whole pipeline advances as a unit whenever the output slot is empty or being drained.
// Optional build macro: SATURATE_EN. It clamps sum to the signed limit on overflow, with the
//   sign of a choosing the limit.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      operands accepted this cycle
//   a, b       in   WIDTH  operands
//   cin        in   1      carry-in (add) / borrow-in (sub)
//   sub        in   1      0: a+b+cin, 1: a-b-cin
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result
//   co         out  1      carry-out (sub: 1 = no borrow)
//   ovf        out  1      signed overflow
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             ovf_d;
  logic             ovf_q;

  // Subtraction as a + ~b + 1; a borrow-in removes that +1, hence cin ^ sub.
  always_comb begin
    b_eff = sub ? ~b : b;
    c0    = cin ^ sub;
  end

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Result bits known once this stage's register is loaded.
    localparam int RW = (k + 1) * CHUNK;

    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] s_c;
    logic [CHUNK:0]   cc;
    logic             v_i;
    logic [RW-1:0]    r_raw;
    logic [RW-1:0]    r_d;
    logic [RW-1:0]    r_q;
    logic             c_d;
    logic             c_q;
    logic             v_d;
    logic             v_q;

    if (k == 0) begin : g_src
      assign a_c   = a[CHUNK-1:0];
      assign b_c   = b_eff[CHUNK-1:0];
      assign cc[0] = c0;
      assign v_i   = in_valid;
      assign r_raw = s_c;
    end else begin : g_src
      // The lowest pending operand chunk of the previous stage belongs to this stage.
      assign a_c   = g_stage[k-1].g_fwd.a_q[CHUNK-1:0];
      assign b_c   = g_stage[k-1].g_fwd.b_q[CHUNK-1:0];
      assign cc[0] = g_stage[k-1].c_q;
      assign v_i   = g_stage[k-1].v_q;
      assign r_raw = {s_c, g_stage[k-1].r_q};
    end

    for (genvar j = 0; j < CHUNK; j++) begin : g_bit
      fa u_fa (
        .a  (a_c[j]),
        .b  (b_c[j]),
        .ci (cc[j]),
        .s  (s_c[j]),
        .co (cc[j+1])
      );
    end

    if (k == STAGES - 1) begin : g_res
      always_comb begin
        // Overflow: carry into the MSB differs from carry out of it.
        ovf_d = cc[CHUNK] ^ cc[CHUNK-1];
        r_d   = r_raw;
`ifdef SATURATE_EN
        // On overflow the true result has the sign of a; a_c holds a's top chunk here.
        if (ovf_d) begin
          r_d = a_c[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end
    end else begin : g_res
      always_comb begin
        r_d = r_raw;
      end
    end

    always_comb begin
      c_d = cc[CHUNK];
      v_d = v_i;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (adv) begin
        v_q <= v_d;
        c_q <= c_d;
        r_q <= r_d;
      end
    end

    // Operand bits above this stage's chunk, delayed until their own stage.
    if (k < STAGES - 1) begin : g_fwd
      localparam int HI = WIDTH - RW;

      logic [HI-1:0] a_d;
      logic [HI-1:0] b_d;
      logic [HI-1:0] a_q;
      logic [HI-1:0] b_q;

      if (k == 0) begin : g_in
        always_comb begin
          a_d = a[WIDTH-1:CHUNK];
          b_d = b_eff[WIDTH-1:CHUNK];
        end
      end else begin : g_in
        always_comb begin
          a_d = g_stage[k-1].g_fwd.a_q[HI+CHUNK-1:CHUNK];
          b_d = g_stage[k-1].g_fwd.b_q[HI+CHUNK-1:CHUNK];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].r_q;
  assign co        = g_stage[STAGES-1].c_q;
  assign ovf       = ovf_q;

endmodule

// Full-adder cell used to ripple each chunk.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder at STAGES 4, 1 and 16
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        cin;
  logic        sub;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;

  // Index 0: STAGES=4, 1: STAGES=1, 2: STAGES=16.
  logic        ir    [3];
  logic        ov    [3];
  logic        co_o  [3];
  logic        ovf_o [3];
  logic [15:0] sm    [3];
  int          dep   [3] = '{4, 1, 16};

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef SATURATE_EN
  localparam logic [15:0] ADD_OVF_SUM = 16'h7FFF;
  localparam logic [15:0] SUB_OVF_SUM = 16'h8000;
`else
  localparam logic [15:0] ADD_OVF_SUM = 16'h8000;
  localparam logic [15:0] SUB_OVF_SUM = 16'h7FFF;
`endif

  typedef struct packed {
    logic        v;
    logic        ovf;
    logic        co;
    logic [15:0] sum;
  } res_t;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready), .sum(sm[0]),
    .co(co_o[0]), .ovf(ovf_o[0])
  );

  pipelined_adder #(.WIDTH(16), .STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready), .sum(sm[1]),
    .co(co_o[1]), .ovf(ovf_o[1])
  );

  pipelined_adder #(.WIDTH(16), .STAGES(16)) dut_s16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov[2]), .out_ready(out_ready), .sum(sm[2]),
    .co(co_o[2]), .ovf(ovf_o[2])
  );

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic res_t ref_op(input logic [15:0] x, input logic [15:0] y,
                                  input logic ci, input logic s);
    int   ux, uy, sx, sy, ur, sr, c;
    res_t r;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    c  = ci ? 1 : 0;
    if (s) begin
      ur   = ux - uy - c;
      sr   = sx - sy - c;
      r.co = (ur >= 0);
    end else begin
      ur   = ux + uy + c;
      sr   = sx + sy + c;
      r.co = (ur > 65535);
    end
    r.ovf = (sr > 32767) || (sr < -32768);
    r.sum = ur[15:0];
`ifdef SATURATE_EN
    if (r.ovf) r.sum = (sr > 0) ? 16'h7FFF : 16'h8000;
`endif
    r.v = 1'b1;
    return r;
  endfunction

  function automatic logic [15:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one op into an empty pipeline and waits for it on the STAGES=4 instance.
  task automatic run_one(input logic [15:0] x, input logic [15:0] y, input logic ci,
                         input logic s, output res_t got, output int lat);
    @(negedge clk);
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (ov[0] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = {ov[0], ovf_o[0], co_o[0], sm[0]};
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests_run++; if (ov[0] !== 1'b0) begin tests_failed++; $display("FAIL reset.out_valid: got %b expected 0", ov[0]); end
    tests_run++; if (sm[0] !== 16'h0000) begin tests_failed++; $display("FAIL reset.sum: got %h expected 0000", sm[0]); end
    tests_run++; if (co_o[0] !== 1'b0) begin tests_failed++; $display("FAIL reset.co: got %b expected 0", co_o[0]); end
    tests_run++; if (ovf_o[0] !== 1'b0) begin tests_failed++; $display("FAIL reset.ovf: got %b expected 0", ovf_o[0]); end
    tests_run++; if (ir[0] !== 1'b1) begin tests_failed++; $display("FAIL reset.in_ready: got %b expected 1", ir[0]); end
    tests_run++; if (ov[1] !== 1'b0) begin tests_failed++; $display("FAIL reset.out_valid_s1: got %b expected 0", ov[1]); end
    tests_run++; if (ov[2] !== 1'b0) begin tests_failed++; $display("FAIL reset.out_valid_s16: got %b expected 0", ov[2]); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] da [4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] db [4] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic        ds [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es [4] = '{16'h0000, ADD_OVF_SUM, 16'hFFFE, SUB_OVF_SUM};
    logic        ec [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        eo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    res_t got;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      run_one(da[i], db[i], 1'b0, ds[i], got, lat);
      tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL directed%0d.latency: got %0d expected 4", i, lat); end
      tests_run++; if (got.sum !== es[i]) begin tests_failed++; $display("FAIL directed%0d.sum: got %h expected %h", i, got.sum, es[i]); end
      tests_run++; if (got.co !== ec[i]) begin tests_failed++; $display("FAIL directed%0d.co: got %b expected %b", i, got.co, ec[i]); end
      tests_run++; if (got.ovf !== eo[i]) begin tests_failed++; $display("FAIL directed%0d.ovf: got %b expected %b", i, got.ovf, eo[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] oa [8];
    logic [15:0] ob [8];
    logic        oc [8];
    logic        os [8];
    res_t        opr [8];
    res_t        pipe [4];
    int          issued = 0;
    int          popped = 0;
    logic        exp_rdy;
    for (int i = 0; i < 8; i++) begin
      oa[i] = rand_operand(); ob[i] = rand_operand();
      oc[i] = 1'($urandom); os[i] = 1'($urandom);
      opr[i] = ref_op(oa[i], ob[i], oc[i], os[i]);
    end
    for (int i = 0; i < 4; i++) pipe[i] = '0;
    do_reset();
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc <= 7);
      in_valid  = (issued < 8);
      if (issued < 8) begin
        a = oa[issued]; b = ob[issued]; cin = oc[issued]; sub = os[issued];
      end
      #1;
      exp_rdy = !pipe[3].v || out_ready;
      tests_run++;
      if (ov[0] !== pipe[3].v) begin tests_failed++; $display("FAIL b2b.out_valid cyc%0d: got %b expected %b", cyc, ov[0], pipe[3].v); end
      if (pipe[3].v) begin
        tests_run++;
        if ({ovf_o[0], co_o[0], sm[0]} !== {pipe[3].ovf, pipe[3].co, pipe[3].sum}) begin
          tests_failed++;
          $display("FAIL b2b.result cyc%0d: got %h expected %h", cyc, {ovf_o[0], co_o[0], sm[0]}, {pipe[3].ovf, pipe[3].co, pipe[3].sum});
        end
      end
      tests_run++;
      if (ir[0] !== exp_rdy) begin tests_failed++; $display("FAIL b2b.in_ready cyc%0d: got %b expected %b", cyc, ir[0], exp_rdy); end
      if (ov[0] === 1'b1 && out_ready) popped++;
      if (exp_rdy) begin
        for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = in_valid ? opr[issued] : '0;
        if (in_valid) issued++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tests_run++; if (popped != 8) begin tests_failed++; $display("FAIL b2b.count: got %0d expected 8", popped); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = rand_operand(); b = rand_operand(); cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1; out_ready = 1'b1;
      // Fourth op is offered in the reset cycle and must be dropped.
      if (i == 3) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    tests_run++; if (sm[0] !== 16'h0000) begin tests_failed++; $display("FAIL rstmid.sum: got %h expected 0000", sm[0]); end
    for (int cyc = 0; cyc < 20; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        tests_run++;
        if (ov[d] !== 1'b0) begin tests_failed++; $display("FAIL rstmid.out_valid dut%0d cyc%0d: got %b expected 0", d, cyc, ov[d]); end
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_stage_depths();
    res_t hist [$];
    res_t exp_r;
    int   n = 0;
    int   got [3] = '{0, 0, 0};
    do_reset();
    for (int t = 0; t < 1400; t++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (n < 1000 && $urandom_range(0, 9) < 8) begin
        a = rand_operand(); b = rand_operand(); cin = 1'($urandom); sub = 1'($urandom);
        in_valid = 1'b1;
        n++;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        exp_r = (t >= dep[d]) ? hist[t - dep[d]] : '0;
        tests_run++;
        if (ov[d] !== exp_r.v) begin
          tests_failed++;
          $display("FAIL depth%0d.out_valid t%0d: got %b expected %b", dep[d], t, ov[d], exp_r.v);
        end
        if (exp_r.v) begin
          tests_run++;
          if ({ovf_o[d], co_o[d], sm[d]} !== {exp_r.ovf, exp_r.co, exp_r.sum}) begin
            tests_failed++;
            $display("FAIL depth%0d.result t%0d: got %h expected %h", dep[d], t, {ovf_o[d], co_o[d], sm[d]}, {exp_r.ovf, exp_r.co, exp_r.sum});
          end
        end
        if (ov[d] === 1'b1) got[d]++;
      end
      hist.push_back(in_valid ? ref_op(a, b, cin, sub) : res_t'('0));
    end
    in_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      tests_run++;
      if (got[d] != n) begin tests_failed++; $display("FAIL depth%0d.count: got %0d expected %0d", dep[d], got[d], n); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_stage_depths();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
